// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for an integer clock divider with glitch-free reconfiguration
//   i_clk, i_rst_n          system clock, asynchronous active-low reset
//   i_en                    level-sensitive run request
//   i_cfg_valid/o_cfg_ready config handshake; i_cfg_div = period N, i_cfg_high = high phase H
//   o_cfg_err               one-cycle pulse after an invalid config was accepted and dropped
//   o_div_clk, o_tick       registered divided clock and first-high-cycle strobe
//   o_busy                  controller is not idle
module clk_div_ctrl #(
  parameter int CNT_W    = 8,
  parameter int DEF_DIV  = 6,
  parameter int DEF_HIGH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic [CNT_W-1:0] i_cfg_high,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_busy
);
  typedef enum logic [1:0] {IDLE, RUN, PENDING, STOPPING} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, div, high, sdiv, shigh;
  logic pend, xfer, ok, pe;
  assign o_cfg_ready = (state == IDLE) || (state == RUN);
  assign o_busy = state != IDLE;
  assign xfer = i_cfg_valid && o_cfg_ready;
  assign ok = (i_cfg_div >= CNT_W'(2)) && (i_cfg_high != '0) && (i_cfg_high < i_cfg_div);
  assign pe = cnt == div - CNT_W'(1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      div <= CNT_W'(DEF_DIV);
      high <= CNT_W'(DEF_HIGH);
      sdiv <= '0;
      shigh <= '0;
      pend <= 1'b0;
      o_div_clk <= 1'b0;
      o_tick <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      o_div_clk <= (state != IDLE) && (cnt < high);
      o_tick <= (state != IDLE) && (cnt == '0);
      o_cfg_err <= xfer && !ok;
      if (state == IDLE) begin
        cnt <= '0;
        if (xfer && ok) begin
          div <= i_cfg_div;
          high <= i_cfg_high;
        end
        if (i_en) state <= RUN;
      end else begin
        cnt <= pe ? '0 : cnt + CNT_W'(1);
        // only RUN accepts transfers here, so pend is clear whenever the shadow is written
        if (xfer && ok) begin
          sdiv <= i_cfg_div;
          shigh <= i_cfg_high;
          pend <= 1'b1;
        end
        // a pending shadow is committed at any period boundary, including the final one of a stop
        if (pe && pend) begin
          div <= sdiv;
          high <= shigh;
          pend <= 1'b0;
        end
        if (state == STOPPING) begin
          if (pe) state <= IDLE;
        end else if (!i_en) state <= STOPPING;
        else if (state == RUN && xfer && ok) state <= PENDING;
        else if (state == PENDING && pe) state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench for clk_div_ctrl
module tb_clk_div_ctrl;
  logic clk = 1'b0;
  logic rst_n, en, valid;
  logic [7:0] div, high;
  logic ready, err, div_clk, tick, busy;
  int checks = 0, errors = 0, cyc = 0;
  logic [4:0] sb[$];
  clk_div_ctrl #(.CNT_W(8), .DEF_DIV(6), .DEF_HIGH(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cfg_valid(valid),
    .i_cfg_div(div), .i_cfg_high(high), .o_cfg_ready(ready), .o_cfg_err(err),
    .o_div_clk(div_clk), .o_tick(tick), .o_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // entry layout: {div_clk, tick, busy, ready, err}
  task automatic push_start();
    sb.push_back(5'b00110);
  endtask
  task automatic push_idle(input int k);
    repeat (k) sb.push_back(5'b00010);
  endtask
  task automatic push_period(input int n, input int h, input int m, input int rlo, input int rhi, input int e, input bit stop);
    for (int i = 0; i < m; i++)
      sb.push_back({i < h, i == 0, !(stop && i == n - 1), !(i >= rlo && i <= rhi), i == e});
  endtask
  task automatic run(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else chk($sformatf("cyc%0d", cyc), {div_clk, tick, busy, ready, err}, sb.pop_front());
      cyc++;
    end
  endtask
  task automatic cfg(input logic [7:0] n, input logic [7:0] h);
    valid = 1'b1;
    div = n;
    high = h;
  endtask
  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    valid = 1'b0;
    div = '0;
    high = '0;
    @(posedge clk);
    #1;
    chk("rst_out", {div_clk, tick, busy, err}, 0);
    chk("rst_rdy", ready, 1);
    rst_n = 1'b1;
    en = 1'b1;
    push_start();
    repeat (2) push_period(6, 3, 6, 9, 0, -1, 0);
    run(13);
    push_period(6, 3, 6, 1, 4, -1, 0);
    run(1);
    cfg(4, 1);
    run(1);
    valid = 1'b0;
    run(4);
    repeat (2) push_period(4, 1, 4, 9, 0, -1, 0);
    run(8);
    push_period(4, 1, 4, 9, 0, 0, 0);
    cfg(5, 5);
    run(1);
    valid = 1'b0;
    run(3);
    push_period(4, 1, 4, 9, 0, 0, 0);
    cfg(1, 0);
    run(1);
    valid = 1'b0;
    run(3);
    push_period(4, 1, 4, 9, 0, -1, 0);
    run(4);
    push_period(4, 1, 4, 0, 2, -1, 0);
    cfg(6, 3);
    run(1);
    valid = 1'b0;
    run(3);
    push_period(6, 3, 6, 1, 4, -1, 1);
    run(1);
    en = 1'b0;
    run(5);
    push_idle(5);
    run(5);
    push_idle(1);
    cfg(2, 1);
    run(1);
    valid = 1'b0;
    push_start();
    en = 1'b1;
    run(1);
    repeat (3) push_period(2, 1, 2, 9, 0, -1, 0);
    run(6);
    push_period(2, 1, 2, 0, 0, -1, 0);
    cfg(255, 254);
    run(1);
    valid = 1'b0;
    run(1);
    repeat (2) push_period(255, 254, 255, 9, 0, -1, 0);
    run(510);
    push_period(255, 254, 3, 0, 253, -1, 0);
    cfg(10, 5);
    run(1);
    valid = 1'b0;
    run(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", {div_clk, tick, busy, err}, 0);
    chk("async_rst_rdy", ready, 1);
    @(posedge clk);
    #1;
    chk("held_rst_out", {div_clk, tick, busy, err}, 0);
    rst_n = 1'b1;
    push_start();
    repeat (2) push_period(6, 3, 6, 9, 0, -1, 0);
    run(13);
    chk("sb_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
